icache_axi_rd_bridge: RTL and testbench

//  Memory-side responder for the instruction cache miss port. Accepts a word read

---
 rtl/axi_defs.sv | 20 ++
 rtl/icache_axi_rd_bridge.sv | 121 ++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axi_defs.sv
// Shared AXI4 encodings and bridge FSM state encoding.
package axi_defs;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_AR_ENC   = 2'd1;
  localparam logic [1:0] ST_R_ENC    = 2'd2;
  localparam logic [1:0] ST_RESP_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_AR   = ST_AR_ENC,
    ST_R    = ST_R_ENC,
    ST_RESP = ST_RESP_ENC
  } state_t;

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache miss responder: one single-beat AXI4 read per miss,
// returns the word with a one-cycle s_ready qualified by the still-pending request.
module icache_axi_rd_bridge
  import axi_defs::*;
#(
  parameter int              A_WIDTH  = 32,
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] ARID_VAL = '0
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] s_a,
  input  logic               s_strobe,
  output logic [31:0]        s_dout,
  output logic               s_ready,
  output logic               bus_err,
  output logic [ID_W-1:0]    arid,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  input  logic [ID_W-1:0]    rid,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready
);

  state_t               state_q, state_d;
  logic [A_WIDTH-1:2]   addr_q;
  logic                 accept, ar_hs, r_hs;

  // The word offset of the miss address plays no part in the request.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^s_a[1:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and handshake strobes.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ar_hs   = 1'b0;
    r_hs    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = s_strobe;
        if (s_strobe) state_d = ST_AR;
      end
      ST_AR: begin
        ar_hs = arvalid && arready;
        if (ar_hs) state_d = ST_R;
      end
      ST_R: begin
        // A beat without rlast is still taken as the final one.
        r_hs = rvalid && rready;
        if (r_hs) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered AXI controls, latched address, returned data and error pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      arvalid <= 1'b0;
      rready  <= 1'b0;
      addr_q  <= '0;
      s_dout  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (accept) begin
        addr_q  <= s_a[A_WIDTH-1:2];
        arvalid <= 1'b1;
      end
      if (ar_hs) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end
      if (r_hs) begin
        s_dout  <= rdata;
        bus_err <= (rresp != AXI_RESP_OKAY);
        rready  <= 1'b0;
      end
    end
  end

  // Data is only offered while the cache still wants exactly this word.
  assign s_ready = (state_q == ST_RESP) && s_strobe &&
                   (s_a[A_WIDTH-1:2] == addr_q);

  assign araddr  = {addr_q, 2'b00};
  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  a_ar_stable: assert property (@(posedge clk) disable iff (!clrn)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  a_rlast: assert property (@(posedge clk) disable iff (!clrn)
    (rvalid && rready) |-> rlast);

  a_rid: assert property (@(posedge clk) disable iff (!clrn)
    (rvalid && rready) |-> (rid == ARID_VAL));

  a_rready_in_r: assert property (@(posedge clk) disable iff (!clrn)
    rready |-> (state_q == ST_R));

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench: directed vector table, reset corner case, then random misses
// checked against a latency/data model derived from the handshake rules.
module tb_icache_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] s_a;
  logic        s_strobe;
  logic [31:0] s_dout;
  logic        s_ready, bus_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  icache_axi_rd_bridge dut (
    .clk(clk), .clrn(clrn), .s_a(s_a), .s_strobe(s_strobe), .s_dout(s_dout),
    .s_ready(s_ready), .bus_err(bus_err), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  // abort_kind: 0 none, 1 strobe dropped at cycle abort_n, 2 address changed at abort_n
  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_stall;
    int          r_stall;
    int          abort_kind;
    int          abort_n;
    int          skip;
    int          tail;
    int          exp_lat;
    int          exp_ready;
    int          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plays one miss: the bench acts as cache and AXI slave, cycle n counted from the accept edge.
  task automatic run_vec(input vec_t v, input string tag);
    int n, ar_wait, r_wait, ar_hs_cnt, r_hs_cnt, rdy_cnt, rdy_n, err_cnt, addr_bad;
    logic [31:0] got_dout, exp_addr;
    ar_wait = 0; r_wait = 0; ar_hs_cnt = 0; r_hs_cnt = 0;
    rdy_cnt = 0; rdy_n = -1; err_cnt = 0; addr_bad = 0; got_dout = '0;
    exp_addr = {v.addr[31:2], 2'b00};
    s_a = v.addr;
    s_strobe = 1'b1;
    repeat (v.skip + 1) @(posedge clk);
    for (n = 1; n <= v.exp_lat + v.tail; n++) begin
      @(negedge clk);
      if (s_ready) begin
        rdy_cnt++;
        rdy_n = n;
        got_dout = s_dout;
      end
      if (bus_err) err_cnt++;
      if (arvalid && (araddr != exp_addr || arlen != 8'd0 || arsize != 3'b010 ||
                      arburst != 2'b01 || arid != 4'd0))
        addr_bad++;
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
      if (arvalid) begin
        if (ar_wait == v.ar_stall) begin
          arready = 1'b1;
          ar_hs_cnt++;
        end else ar_wait++;
      end
      if (rready) begin
        if (r_wait == v.r_stall) begin
          rvalid = 1'b1;
          rdata  = v.rdata;
          rresp  = v.rresp;
          r_hs_cnt++;
        end else r_wait++;
      end
      if (n == v.abort_n && v.abort_kind == 1) s_strobe = 1'b0;
      if (n == v.abort_n && v.abort_kind == 2) s_a = v.addr ^ 32'h4;
      if (n >= v.exp_lat) s_strobe = 1'b0;
    end
    check($sformatf("%s ready_count", tag), 64'(rdy_cnt), 64'(v.exp_ready));
    if (v.exp_ready != 0) begin
      check($sformatf("%s ready_cycle", tag), 64'(rdy_n), 64'(v.exp_lat));
      check($sformatf("%s s_dout", tag), {32'd0, got_dout}, {32'd0, v.rdata});
    end
    check($sformatf("%s bus_err_pulses", tag), 64'(err_cnt), 64'(v.exp_err));
    check($sformatf("%s ar_handshakes", tag), 64'(ar_hs_cnt), 64'd1);
    check($sformatf("%s r_handshakes", tag), 64'(r_hs_cnt), 64'd1);
    check($sformatf("%s ar_fields_bad_cycles", tag), 64'(addr_bad), 64'd0);
  endtask

  initial begin
    vec_t rv;
    int   r;
    clrn = 1'b0; s_a = '0; s_strobe = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    rid = 4'd0; rlast = 1'b1;

    //           addr           rdata          rresp  ars rs ab abn sk tl lat rdy err
    vecs[0] = '{32'hBFC0_0004, 32'h2402_0001, 2'b00, 0, 0, 0, 0, 0, 2, 3,  1, 0};
    vecs[1] = '{32'h8000_1000, 32'h1234_5678, 2'b00, 5, 3, 0, 0, 0, 2, 11, 1, 0};
    vecs[2] = '{32'h8000_2000, 32'hCAFE_F00D, 2'b00, 0, 2, 1, 3, 0, 2, 5,  0, 0};
    vecs[3] = '{32'h0000_0100, 32'h1111_1111, 2'b00, 0, 0, 0, 0, 0, 0, 3,  1, 0};
    vecs[4] = '{32'h0000_0104, 32'h2222_2222, 2'b00, 1, 0, 0, 0, 1, 2, 4,  1, 0};
    vecs[5] = '{32'h0000_0200, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0, 2, 3,  1, 1};
    vecs[6] = '{32'h0000_0303, 32'h5555_AAAA, 2'b00, 1, 1, 2, 2, 0, 2, 5,  0, 0};
    vecs[7] = '{32'h0000_0040, 32'h0BAD_F00D, 2'b11, 2, 2, 0, 0, 0, 2, 7,  1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset arvalid", 64'(arvalid), 64'd0);
    check("reset rready", 64'(rready), 64'd0);
    check("reset s_ready", 64'(s_ready), 64'd0);
    check("reset bus_err", 64'(bus_err), 64'd0);
    check("reset araddr", 64'(araddr), 64'd0);
    check("reset s_dout", 64'(s_dout), 64'd0);
    check("const arlen", 64'(arlen), 64'd0);
    check("const arsize", 64'(arsize), 64'd2);
    check("const arburst", 64'(arburst), 64'd1);
    check("const arid", 64'(arid), 64'd0);
    clrn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while waiting for arready.
    s_a = 32'h0000_0500;
    s_strobe = 1'b1;
    arready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset arvalid", 64'(arvalid), 64'd1);
    #2 clrn = 1'b0;
    #1;
    check("async_reset arvalid", 64'(arvalid), 64'd0);
    check("async_reset s_ready", 64'(s_ready), 64'd0);
    check("async_reset araddr", 64'(araddr), 64'd0);
    s_strobe = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], "post_reset");

    // Random misses: expectations from the handshake rules (3 cycles plus one per stall).
    for (int k = 0; k < 40; k++) begin
      rv.addr     = $urandom;
      rv.rdata    = $urandom;
      rv.rresp    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv.ar_stall = $urandom_range(0, 4);
      rv.r_stall  = $urandom_range(0, 4);
      rv.skip     = 0;
      rv.tail     = $urandom_range(1, 2);
      rv.exp_lat  = 3 + rv.ar_stall + rv.r_stall;
      r = $urandom_range(0, 7);
      rv.abort_kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      rv.abort_n    = $urandom_range(1, rv.exp_lat - 1);
      rv.exp_ready  = (rv.abort_kind == 0) ? 1 : 0;
      rv.exp_err    = (rv.rresp != 2'b00) ? 1 : 0;
      run_vec(rv, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
